// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_e                  : FSM states (IDLE, SHIFT, DONE)
//   SERIAL_SUB_WIDTH_DEFAULT : default operand width in bits
package serial_sub_pkg;

  localparam int unsigned SERIAL_SUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor.
//   start, a, b, bin       : request side (driven by the controller)
//   busy, done, diff, bout, ovf : status/result side (driven by the subtractor)
// Modports: master = controller, slave = subtractor.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_SUB_WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
//   a, b, bin : input bits
//   d         : difference bit
//   bout      : borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// using a single full_subtractor cell and a borrow flop.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : serial_subtractor_if.slave (start/a/b/bin in; busy/done/diff/bout/ovf out)
// Optional feature: define SERIAL_SUB_OVF_EN to generate the signed overflow
// flag; otherwise ovf is tied to 0.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_SUB_WIDTH_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             cell_d;
  logic             cell_bout;
  logic             accept;
  logic [WIDTH-1:0] res_shifted;

  full_subtractor u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    br_d     = br_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif

    // Start is honoured in IDLE and DONE alike, so DONE can chain straight
    // into the next operation without passing through IDLE.
    accept      = bus.start && (state_q != SHIFT);
    res_shifted = {cell_d, res_sr_q[WIDTH-1:1]};

    case (state_q)
      SHIFT: begin
        res_sr_d = res_shifted;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        br_d     = cell_bout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          diff_d  = res_shifted;
          bout_d  = cell_bout;
`ifdef SERIAL_SUB_OVF_EN
          // Borrow into the MSB differs from borrow out of it exactly when
          // the signed result left the representable range.
          ovf_d   = br_q ^ cell_bout;
`endif
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_sr_d   = bus.a;
      b_sr_d   = bus.b;
      br_d     = bus.bin;
      res_sr_d = '0;
      cnt_d    = '0;
      state_d  = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      br_q     <= br_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`else
  assign bus.ovf  = 1'b0;
`endif

endmodule
